mem_arbiter: RTL and testbench

Shared line-fill arbiter between the L1 caches (instruction cache, data cache) and the backing memory port. It hands out request IDs, grants one cache a request slot at a time using a rotating token, and queues accepted line requests in a FIFO. It issues queued requests to memory one at a time and broadcasts each returned line with its ID until the requesting cache acknowledges it.

---
 rtl/const_pkg.sv | 28 ++
 rtl/arb_fifo.sv | 54 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/const_pkg.sv
// Shared widths and types for the L1 line-fill path (arbiter, caches).
package const_pkg;

  localparam int unsigned PA_WIDTH   = 32;
  localparam int unsigned LINE_WIDTH = 64;
  localparam int unsigned ID_WIDTH   = 3;

  // Memory-side sequencer of the line-fill arbiter
  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_WAIT,
    M_RESP
  } mem_arbiter_s;

  // Grant token phase: a port is first offered a slot, then may claim it
  typedef enum logic {
    PH_OFFER,
    PH_CLAIM
  } token_phase_e;

  // One queued line request
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [PA_WIDTH-1:0] addr;
  } fifo_entry_t;

endpackage

// File: rtl/arb_fifo.sv
// Synchronous FIFO holding outstanding line requests; head is the oldest entry.
module arb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Line-fill arbiter: rotating grant token hands out request IDs to the caches,
// accepted requests are queued and issued to memory one at a time, and each
// returned line is broadcast with its ID until a cache acknowledges it.
module mem_arbiter
  import const_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               i_req_enable,
  input  logic [N_PORTS-1:0][PA_WIDTH-1:0] i_req_addr,
  input  logic [N_PORTS-1:0]               i_ack,
  output logic [ID_WIDTH-1:0]              o_id_request,
  output logic [N_PORTS-1:0]               o_in_use,
  output logic                             o_resp_enable,
  output logic [LINE_WIDTH-1:0]            o_resp_data,
  output logic [ID_WIDTH-1:0]              o_resp_id,
  output logic                             o_dram_req,
  output logic [PA_WIDTH-1:0]              o_dram_addr,
  input  logic                             i_dram_ready,
  input  logic                             i_dram_valid,
  input  logic [LINE_WIDTH-1:0]            i_dram_data
);

  localparam int unsigned TW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [TW-1:0]                tok;
  token_phase_e                 phase;
  logic                         live;
  logic                         offered;
  logic                         claim_accept;
  fifo_entry_t                  push_entry;
  fifo_entry_t                  head;
  logic [$bits(fifo_entry_t)-1:0] head_bits;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         pop;
  mem_arbiter_s                 mstate;

  // A claim only counts if the preceding OFFER actually lowered o_in_use
  assign claim_accept    = live && (phase == PH_CLAIM) && offered && i_req_enable[tok];
  assign push_entry.id   = o_id_request;
  assign push_entry.addr = i_req_addr[tok];
  assign head            = head_bits;
  assign pop             = (mstate == M_RESP) && (|i_ack);

  arb_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (claim_accept),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  // Token rotation and ID allocation; 'live' holds the token one cycle after
  // reset so o_in_use reads all ones in reset yet port 0 still gets the first offer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tok          <= '0;
      phase        <= PH_OFFER;
      live         <= 1'b0;
      offered      <= 1'b0;
      o_id_request <= '0;
    end else begin
      live <= 1'b1;
      if (live) begin
        if (phase == PH_OFFER) begin
          offered <= !fifo_full;
          phase   <= PH_CLAIM;
        end else begin
          phase <= PH_OFFER;
          if (tok == TW'(N_PORTS - 1)) tok <= '0;
          else                         tok <= tok + TW'(1);
          if (claim_accept) o_id_request <= o_id_request + ID_WIDTH'(1);
        end
      end
    end
  end

  // Grant visibility, decoded from token state and FIFO occupancy only
  always_comb begin
    o_in_use = '1;
    if (live && (phase == PH_OFFER) && !fifo_full) o_in_use[tok] = 1'b0;
  end

  // Memory sequencer with registered request and broadcast outputs; an entry
  // being pushed into an empty FIFO is issued directly to save a cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstate        <= M_IDLE;
      o_dram_req    <= 1'b0;
      o_dram_addr   <= '0;
      o_resp_enable <= 1'b0;
      o_resp_data   <= '0;
      o_resp_id     <= '0;
    end else begin
      case (mstate)
        M_IDLE: begin
          if (!fifo_empty) begin
            mstate      <= M_REQ;
            o_dram_req  <= 1'b1;
            o_dram_addr <= head.addr;
          end else if (claim_accept) begin
            mstate      <= M_REQ;
            o_dram_req  <= 1'b1;
            o_dram_addr <= push_entry.addr;
          end
        end
        M_REQ: begin
          if (i_dram_ready) begin
            mstate     <= M_WAIT;
            o_dram_req <= 1'b0;
          end
        end
        M_WAIT: begin
          if (i_dram_valid) begin
            mstate        <= M_RESP;
            o_resp_enable <= 1'b1;
            o_resp_data   <= i_dram_data;
            o_resp_id     <= head.id;
          end
        end
        M_RESP: begin
          if (|i_ack) begin
            mstate        <= M_IDLE;
            o_resp_enable <= 1'b0;
          end
        end
        default: mstate <= M_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed
// scenarios with hand-computed expectations.
module tb_mem_arbiter;
  import const_pkg::*;

  localparam int MDEPTH = 4;

  logic                       clk;
  logic                       rst;
  logic [1:0]                 req_en;
  logic [1:0][PA_WIDTH-1:0]   req_addr;
  logic [1:0]                 ack;
  logic [ID_WIDTH-1:0]        id_request;
  logic [1:0]                 in_use;
  logic                       resp_enable;
  logic [LINE_WIDTH-1:0]      resp_data;
  logic [ID_WIDTH-1:0]        resp_id;
  logic                       dram_req;
  logic [PA_WIDTH-1:0]        dram_addr;
  logic                       dram_ready;
  logic                       dram_valid;
  logic [LINE_WIDTH-1:0]      dram_data;

  mem_arbiter #(.N_PORTS(2), .DEPTH(MDEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_enable (req_en),
    .i_req_addr   (req_addr),
    .i_ack        (ack),
    .o_id_request (id_request),
    .o_in_use     (in_use),
    .o_resp_enable(resp_enable),
    .o_resp_data  (resp_data),
    .o_resp_id    (resp_id),
    .o_dram_req   (dram_req),
    .o_dram_addr  (dram_addr),
    .i_dram_ready (dram_ready),
    .i_dram_valid (dram_valid),
    .i_dram_data  (dram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [LINE_WIDTH-1:0] line_of(input logic [PA_WIDTH-1:0] a);
    return {a, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [PA_WIDTH-1:0] addr;
  } ment_t;

  ment_t               q[$];
  int                  mtok;
  bit                  mclaim, mwarm, moff, minfl, mpend;
  logic [ID_WIDTH-1:0] mid;

  initial begin
    ment_t e;
    int    sz0;
    mtok = 0; mclaim = 0; mwarm = 0; moff = 0; minfl = 0; mpend = 0; mid = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mtok = 0; mclaim = 0; mwarm = 0; moff = 0; minfl = 0; mpend = 0; mid = '0;
        q.delete();
      end else begin
        sz0 = q.size();
        for (int p = 0; p < 2; p++)
          if (req_en[p] && !(mwarm && mclaim && moff && p == mtok))
            $display("note: protocol error, port %0d strobe outside its claim slot ignored", p);
        if (mwarm && mclaim && moff && req_en[mtok]) begin
          e.id = mid; e.addr = req_addr[mtok];
          q.push_back(e);
          mid = mid + 1'b1;
        end
        if (mpend && (|ack)) begin
          void'(q.pop_front());
          mpend = 0; minfl = 0;
        end else if (minfl && !mpend && dram_valid) begin
          mpend = 1;
        end
        if (dram_req && dram_ready) minfl = 1;
        if (!mwarm) mwarm = 1;
        else if (!mclaim) begin
          moff = (sz0 < MDEPTH); mclaim = 1;
        end else begin
          mclaim = 0; mtok = (mtok + 1) % 2;
        end
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model
  initial begin
    logic [1:0] exp_use;
    forever begin
      @(negedge clk);
      exp_use = (mwarm && !mclaim && q.size() < MDEPTH) ? ~(2'b01 << mtok) : 2'b11;
      check("model_in_use", in_use, exp_use);
      check("model_id_request", id_request, mid);
      check("model_resp_enable", resp_enable, mpend);
      if (mpend && q.size() > 0) begin
        check("model_resp_id", resp_id, q[0].id);
        check("model_resp_data", resp_data, line_of(q[0].addr));
      end
      if (dram_req) begin
        check("model_dram_req_legal", (q.size() != 0 && !minfl), 1);
        if (q.size() != 0) check("model_dram_addr", dram_addr, q[0].addr);
      end
    end
  end

  // Memory responder: one line, lat cycles after the handshake
  initial begin
    logic [PA_WIDTH-1:0] a;
    dram_valid = 1'b0;
    dram_data  = '0;
    forever begin
      @(negedge clk);
      if (rst && dram_req && dram_ready) begin
        a = dram_addr;
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #2 dram_valid = 1'b1; dram_data = line_of(a);
        @(posedge clk);
        #2 dram_valid = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic claim(input int p, input logic [PA_WIDTH-1:0] a, output int offer_cyc);
    int n;
    n = 0;
    while (in_use[p] !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("offer_timeout", 0, 1);
    offer_cyc = cyc;
    step();
    req_en[p] = 1'b1; req_addr[p] = a;
    step();
    req_en = '0;
  endtask

  task automatic wait_resp(output int rc);
    int n;
    n = 0;
    while (resp_enable !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("resp_timeout", 0, 1);
    rc = cyc;
  endtask

  task automatic serve(input logic [ID_WIDTH-1:0] exp_id, input int p);
    int rc;
    wait_resp(rc);
    check("serve_resp_id", resp_id, exp_id);
    ack[p] = 1'b1;
    step();
    ack = '0;
    check("serve_resp_drop", resp_enable, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  logic [1:0] idle_pat [6] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10};

  initial begin
    int oc, rc, nreq;
    rst = 1'b1; req_en = '0; req_addr = '0; ack = '0; dram_ready = 1'b1;
    #1 rst = 1'b0;

    // Reset values
    step(); step();
    check("rst_in_use", in_use, 2'b11);
    check("rst_id_request", id_request, 0);
    check("rst_resp_enable", resp_enable, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_dram_req", dram_req, 0);
    check("rst_dram_addr", dram_addr, 0);
    rst = 1'b1;

    // Idle token rotation
    for (int i = 0; i < 6; i++) begin
      check("idle_in_use", in_use, idle_pat[i]);
      check("idle_dram_req", dram_req, 0);
      check("idle_id", id_request, 0);
      step();
    end

    // Single port-0 miss, memory latency 3
    lat = 3;
    claim(0, 32'h0000_1000, oc);
    check("p0_id_request", id_request, 1);
    check("p0_dram_req", dram_req, 1);
    check("p0_dram_addr", dram_addr, 32'h0000_1000);
    wait_resp(rc);
    check("p0_latency", rc - oc, 7);
    check("p0_resp_id", resp_id, 0);
    check("p0_resp_data", resp_data, 64'h0000_1000_FFFF_EFFF);
    step();
    check("p0_resp_held", resp_enable, 1);
    ack[0] = 1'b1;
    step();
    ack = '0;
    check("p0_resp_fall", resp_enable, 0);

    // Both ports strobe while port 1 holds the token
    lat = 1;
    nreq = 0;
    while (in_use[1] !== 1'b0 && nreq < 50) begin step(); nreq++; end
    step();
    req_en = 2'b11; req_addr[0] = 32'h0000_2000; req_addr[1] = 32'h0000_3000;
    step();
    req_en = '0;
    check("both_id_request", id_request, 2);
    check("both_dram_req", dram_req, 1);
    check("both_dram_addr", dram_addr, 32'h0000_3000);
    serve(3'd1, 1);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      if (dram_req) nreq++;
      step();
    end
    check("both_single_issue", nreq, 0);

    // Stalled memory fills the FIFO, then drains in order
    apply_reset();
    dram_ready = 1'b0;
    lat = 0;
    for (int i = 0; i < 4; i++) claim(i % 2, 32'h0000_4000 + 32'(i * 'h40), oc);
    check("full_id_request", id_request, 4);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_use !== 2'b11) nreq++;
      step();
    end
    check("full_in_use_held", nreq, 0);
    dram_ready = 1'b1;
    for (int i = 0; i < 4; i++) serve(ID_WIDTH'(i), i % 2);

    // ID wrap: four more completions take the allocator back to 0
    for (int i = 0; i < 6; i++) begin
      lat = i % 3;
      claim(i % 2, 32'h0000_8000 + 32'(i * 'h100), oc);
      serve(ID_WIDTH'(4 + i), i % 2);
      if (i == 3) check("wrap_id_request", id_request, 0);
    end
    check("wrap_after", id_request, 2);

    // Reset asserted during a held broadcast
    lat = 2;
    claim(1, 32'h0000_A000, oc);
    wait_resp(rc);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_resp_enable", resp_enable, 0);
    check("mid_rst_dram_req", dram_req, 0);
    check("mid_rst_in_use", in_use, 2'b11);
    check("mid_rst_id", id_request, 0);
    step(); step();
    rst = 1'b1;
    check("post_rst_warm", in_use, 2'b11);
    step();
    check("post_rst_offer_p0", in_use, 2'b10);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      if (dram_req) nreq++;
      step();
    end
    check("post_rst_fifo_empty", nreq, 0);
    lat = 0;
    claim(0, 32'h0000_B000, oc);
    serve(3'd0, 0);

    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
